// File: rtl/tqvp_vga_sync_decoder.sv
// Receive-side VGA sync decoder: recovers pixel/line position from raw hsync/vsync,
// measures line/frame periods and sync widths, and declares lock after stable frames.
module tqvp_vga_sync_decoder #(
  parameter int CNT_W       = 12,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             polarity,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] v_total,
  output logic [CNT_W-1:0] h_sync_w,
  output logic [CNT_W-1:0] v_sync_w,
  output logic             line_start,
  output logic             frame_start,
  output logic             locked,
  output logic             lost_lock
);

  localparam int               MC_W     = $clog2(LOCK_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [MC_W-1:0]  MC_ZERO  = {MC_W{1'b0}};
  localparam logic [MC_W-1:0]  MC_ONE   = MC_W'(1'b1);
  localparam logic [MC_W-1:0]  MC_LOCK  = MC_W'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) return CNT_MAX;
    else              return v + CNT_ONE;
  endfunction

  logic [1:0]       rst_sync_r;
  logic             rst_int_n_s;
  logic [2:0]       h_pipe_r, v_pipe_r, vld_r;
  logic             h_lvl_s, v_lvl_s, h_edge_s, v_edge_s;
  logic             h_rise_s, h_fall_s, v_rise_s, v_fall_s;
  logic [CNT_W-1:0] pix_x_r, pix_y_r, h_total_r, v_total_r, h_sync_w_r, v_sync_w_r;
  logic             line_start_r, frame_start_r, locked_r, lost_lock_r;
  state_t           state_r, fsm_nxt_s, state_nxt_s;
  logic [MC_W-1:0]  match_cnt_r, match_cnt_nxt_s;
  logic [CNT_W-1:0] ref_h_r, ref_h_nxt_s, ref_v_r, ref_v_nxt_s;
  logic             ref_valid_r, ref_valid_nxt_s;
  logic [CNT_W-1:0] h_new_s, v_new_s;
  logic             timeout_s;

  // Reset synchroniser: asserts immediately, releases on clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_r <= 2'b00;
    else        rst_sync_r <= {rst_sync_r[0], 1'b1};
  end

  assign rst_int_n_s = rst_sync_r[1];

  // Pin synchronisers plus a fill flag so reset values never look like an edge
  always_ff @(posedge clk or negedge rst_int_n_s) begin
    if (!rst_int_n_s) begin
      h_pipe_r <= 3'b000;
      v_pipe_r <= 3'b000;
      vld_r    <= 3'b000;
    end else begin
      h_pipe_r <= {h_pipe_r[1:0], hsync_in};
      v_pipe_r <= {v_pipe_r[1:0], vsync_in};
      vld_r    <= {vld_r[1:0], 1'b1};
    end
  end

  assign h_lvl_s   = h_pipe_r[1] ^ ~polarity;
  assign v_lvl_s   = v_pipe_r[1] ^ ~polarity;
  assign h_edge_s  = vld_r[2] & (h_pipe_r[1] ^ h_pipe_r[2]);
  assign v_edge_s  = vld_r[2] & (v_pipe_r[1] ^ v_pipe_r[2]);
  assign h_rise_s  = h_edge_s & h_lvl_s;
  assign h_fall_s  = h_edge_s & ~h_lvl_s;
  assign v_rise_s  = v_edge_s & v_lvl_s;
  assign v_fall_s  = v_edge_s & ~v_lvl_s;
  assign h_new_s   = h_rise_s ? sat_inc(pix_x_r) : h_total_r;
  assign v_new_s   = sat_inc(pix_y_r);
  assign timeout_s = (pix_x_r == CNT_MAX);

  // Position counters and measurements; a vsync edge overrides the line increment
  always_ff @(posedge clk or negedge rst_int_n_s) begin
    if (!rst_int_n_s) begin
      pix_x_r       <= CNT_ZERO;
      pix_y_r       <= CNT_ZERO;
      h_total_r     <= CNT_ZERO;
      v_total_r     <= CNT_ZERO;
      h_sync_w_r    <= CNT_ZERO;
      v_sync_w_r    <= CNT_ZERO;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      line_start_r  <= h_rise_s;
      frame_start_r <= v_rise_s;
      if (h_rise_s) begin
        h_total_r <= sat_inc(pix_x_r);
        pix_x_r   <= CNT_ZERO;
      end else begin
        pix_x_r   <= sat_inc(pix_x_r);
      end
      if (h_fall_s) h_sync_w_r <= sat_inc(pix_x_r);
      if (v_rise_s) begin
        v_total_r <= sat_inc(pix_y_r);
        pix_y_r   <= CNT_ZERO;
      end else if (h_rise_s) begin
        pix_y_r   <= sat_inc(pix_y_r);
      end
      if (v_fall_s) v_sync_w_r <= sat_inc(pix_y_r);
    end
  end

  // Lock FSM next-state logic
  always_comb begin
    fsm_nxt_s       = state_r;
    match_cnt_nxt_s = match_cnt_r;
    ref_h_nxt_s     = ref_h_r;
    ref_v_nxt_s     = ref_v_r;
    ref_valid_nxt_s = ref_valid_r;
    case (state_r)
      ST_SEARCH: begin
        if (v_rise_s) begin
          fsm_nxt_s       = ST_MEASURE;
          match_cnt_nxt_s = MC_ZERO;
          ref_valid_nxt_s = 1'b0;
        end else begin
          fsm_nxt_s       = ST_SEARCH;
        end
      end
      ST_MEASURE: begin
        if (v_rise_s) begin
          if (ref_valid_r && (h_new_s == ref_h_r) && (v_new_s == ref_v_r)) begin
            match_cnt_nxt_s = match_cnt_r + MC_ONE;
          end else begin
            match_cnt_nxt_s = MC_ZERO;
          end
          ref_h_nxt_s     = h_new_s;
          ref_v_nxt_s     = v_new_s;
          ref_valid_nxt_s = 1'b1;
          if (match_cnt_nxt_s == MC_LOCK) fsm_nxt_s = ST_LOCKED;
          else                            fsm_nxt_s = ST_MEASURE;
        end else begin
          fsm_nxt_s = ST_MEASURE;
        end
      end
      ST_LOCKED: begin
        if ((h_rise_s && (h_new_s != ref_h_r)) || (v_rise_s && (v_new_s != ref_v_r))) begin
          fsm_nxt_s = ST_SEARCH;
        end else begin
          fsm_nxt_s = ST_LOCKED;
        end
      end
      default: begin
        fsm_nxt_s = ST_SEARCH;
      end
    endcase
  end

  assign state_nxt_s = timeout_s ? ST_SEARCH : fsm_nxt_s;

  // Lock FSM state, references and lock status outputs
  always_ff @(posedge clk or negedge rst_int_n_s) begin
    if (!rst_int_n_s) begin
      state_r     <= ST_SEARCH;
      match_cnt_r <= MC_ZERO;
      ref_h_r     <= CNT_ZERO;
      ref_v_r     <= CNT_ZERO;
      ref_valid_r <= 1'b0;
      locked_r    <= 1'b0;
      lost_lock_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      match_cnt_r <= match_cnt_nxt_s;
      ref_h_r     <= ref_h_nxt_s;
      ref_v_r     <= ref_v_nxt_s;
      ref_valid_r <= ref_valid_nxt_s;
      locked_r    <= (state_nxt_s == ST_LOCKED);
      lost_lock_r <= (state_r == ST_LOCKED) && (state_nxt_s != ST_LOCKED);
    end
  end

  assign pix_x       = pix_x_r;
  assign pix_y       = pix_y_r;
  assign h_total     = h_total_r;
  assign v_total     = v_total_r;
  assign h_sync_w    = h_sync_w_r;
  assign v_sync_w    = v_sync_w_r;
  assign line_start  = line_start_r;
  assign frame_start = frame_start_r;
  assign locked      = locked_r;
  assign lost_lock   = lost_lock_r;

endmodule

// File: tb/tb_tqvp_vga_sync_decoder.sv
// Directed bench for tqvp_vga_sync_decoder: 16-clock lines, 10-line frames,
// glitch, timeout, inverted polarity and mid-frame reset.
module tb_tqvp_vga_sync_decoder;

  logic        clk;
  logic        rst_n;
  logic        hsync_in;
  logic        vsync_in;
  logic        polarity;
  logic [11:0] pix_x, pix_y, h_total, v_total, h_sync_w, v_sync_w;
  logic        line_start, frame_start, locked, lost_lock;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   lost_cnt = 0;
  int   lost_base;
  int   max_x, max_y;
  int   fs_pix_y = -1;
  logic ls_seen, fs_seen;

  tqvp_vga_sync_decoder #(.CNT_W(12), .LOCK_FRAMES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .polarity   (polarity),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .h_total    (h_total),
    .v_total    (v_total),
    .h_sync_w   (h_sync_w),
    .v_sync_w   (v_sync_w),
    .line_start (line_start),
    .frame_start(frame_start),
    .locked     (locked),
    .lost_lock  (lost_lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // One clock: sample outputs just after the edge, then drive the pins for the next edge
  task automatic tick(input logic h_act, input logic v_act);
    @(posedge clk);
    #1;
    if (int'(pix_x) > max_x) max_x = int'(pix_x);
    if (int'(pix_y) > max_y) max_y = int'(pix_y);
    if (lost_lock) lost_cnt++;
    if (frame_start) fs_pix_y = int'(pix_y);
    ls_seen  = line_start;
    fs_seen  = frame_start;
    hsync_in = polarity ? h_act : ~h_act;
    vsync_in = polarity ? v_act : ~v_act;
  endtask

  task automatic send_line(input int len, input logic v_act);
    for (int i = 0; i < len; i++) tick(i < 2, v_act);
  endtask

  task automatic send_frame();
    for (int l = 0; l < 10; l++) send_line(16, l < 2);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pix_x"},    32'(pix_x),    32'd0);
    check({tag, "_pix_y"},    32'(pix_y),    32'd0);
    check({tag, "_h_total"},  32'(h_total),  32'd0);
    check({tag, "_v_total"},  32'(v_total),  32'd0);
    check({tag, "_h_sync_w"}, 32'(h_sync_w), 32'd0);
    check({tag, "_v_sync_w"}, 32'(v_sync_w), 32'd0);
    check({tag, "_flags"},    32'({line_start, frame_start, locked, lost_lock}), 32'd0);
  endtask

  task automatic check_meas(input string tag);
    check({tag, "_h_total"},  32'(h_total),  32'd16);
    check({tag, "_v_total"},  32'(v_total),  32'd10);
    check({tag, "_h_sync_w"}, 32'(h_sync_w), 32'd2);
    check({tag, "_v_sync_w"}, 32'(v_sync_w), 32'd2);
  endtask

  initial begin
    rst_n    = 1'b0;
    polarity = 1'b1;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    repeat (8) tick(1'b0, 1'b0);

    // Latency: both pins go active together; pulses only in the third sample after the edge
    for (int k = 0; k < 16; k++) begin
      tick(k < 2, 1'b1);
      if (k <= 6) begin
        check($sformatf("lat_line_start_%0d", k), 32'(ls_seen), 32'(k == 3));
        check($sformatf("lat_frame_start_%0d", k), 32'(fs_seen), 32'(k == 3));
      end
    end
    for (int l = 1; l < 10; l++) send_line(16, l < 2);

    // Lock: three vsync edges so far is not enough, the fourth locks
    send_frame();
    send_frame();
    check("t2_not_yet_locked", 32'(locked), 32'd0);
    max_x = 0;
    max_y = 0;
    send_frame();
    check("t2_locked", 32'(locked), 32'd1);
    check_meas("t2");
    check("t2_max_pix_x", 32'(max_x), 32'd15);
    check("t2_max_pix_y", 32'(max_y), 32'd9);
    check("t6_pix_y_at_frame_start", 32'(fs_pix_y), 32'd0);

    // Line glitch: one 17-clock line drops lock with a single lost_lock pulse
    lost_base = lost_cnt;
    for (int l = 0; l < 4; l++) send_line(16, l < 2);
    send_line(17, 1'b0);
    send_line(8, 1'b0);
    check("t3_h_total_glitch", 32'(h_total), 32'd17);
    check("t3_unlocked", 32'(locked), 32'd0);
    check("t3_lost_pulses", 32'(lost_cnt - lost_base), 32'd1);
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b0);
    for (int l = 6; l < 10; l++) send_line(16, 1'b0);
    send_frame();
    send_frame();
    send_frame();
    check("t3_relock_early", 32'(locked), 32'd0);
    send_frame();
    check("t3_relocked", 32'(locked), 32'd1);
    check("t3_lost_pulses_after", 32'(lost_cnt - lost_base), 32'd1);

    // Timeout: hsync held deasserted until pix_x saturates
    lost_base = lost_cnt;
    for (int i = 0; i < 4200; i++) tick(1'b0, 1'b0);
    check("t4_pix_x_sat", 32'(pix_x), 32'd4095);
    check("t4_unlocked", 32'(locked), 32'd0);
    check("t4_lost_pulses", 32'(lost_cnt - lost_base), 32'd1);

    // Inverted polarity after a fresh reset
    rst_n    = 1'b0;
    polarity = 1'b0;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    repeat (3) tick(1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (8) tick(1'b0, 1'b0);
    send_frame();
    send_frame();
    send_frame();
    check("t5_not_yet_locked", 32'(locked), 32'd0);
    send_frame();
    check("t5_locked", 32'(locked), 32'd1);
    check_meas("t5");

    // Mid-frame reset: outputs clear before the next clock edge
    for (int l = 0; l < 5; l++) send_line(16, l < 2);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("t1_mid_reset");
    repeat (3) tick(1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (8) tick(1'b0, 1'b0);
    send_frame();
    check("t1_search_after_release", 32'(locked), 32'd0);
    send_frame();
    send_frame();
    send_frame();
    check("t1_relocked", 32'(locked), 32'd1);
    check_meas("t1");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
